// File: rtl/jtag_reg_pkg.sv
// Shared types, frame-geometry helpers and constants for the JTAG register bank.
package jtag_reg_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ER1  = 2'd1,
    SEL_ER2  = 2'd2
  } sel_e;

  localparam int unsigned ER2_W       = 64;
  localparam int unsigned ADDR_LSB    = 1;
  localparam logic [31:0] ID_CODE_DEF = 32'h4A544731;

  // ER1 frame without the optional parity bit: {data, addr, wr}
  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int unsigned data_lsb(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Counter must reach w+1 so that over-length frames are distinguishable
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/jtag_reg_bank_if.sv
// JTAGG user-register signal group; master is the JTAGG/host side, slave the register bank.
interface jtag_reg_bank_if;
  logic JTDI;
  logic JSHIFT;
  logic JUPDATE;
  logic JCE1;
  logic JCE2;
  logic JRTI1;
  logic JRTI2;
  logic JTDO1;
  logic JTDO2;

  modport master (
    output JTDI, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1, JRTI2,
    input  JTDO1, JTDO2
  );

  modport slave (
    input  JTDI, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1, JRTI2,
    output JTDO1, JTDO2
  );
endinterface

// File: rtl/jtag_shift_frame.sv
// Capture/shift register for one JTAG data register: LSB-first, TDI enters at the MSB,
// registered TDO and a bit counter that saturates one past the frame width.
module jtag_shift_frame
  import jtag_reg_pkg::*;
#(
  parameter int unsigned W = 37
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic                  shift,
  input  logic                  tdi,
  input  logic [W-1:0]          cap_data,
  output logic [W-1:0]          shreg,
  output logic [cnt_w(W)-1:0]   bit_cnt,
  output logic                  tdo
);

  localparam int unsigned CW = cnt_w(W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      tdo     <= 1'b0;
    end else if (capture) begin
      shreg   <= cap_data;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg <= {tdi, shreg[W-1:1]};
      tdo   <= shreg[0];
      if (bit_cnt != CW'(W + 1))
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_reg_bank.sv
// JTAGG ER1/ER2 bridge onto a bank of NUM_REGS registers; ER2 returns ID and error count.
// Optional even-parity MSB on ER1 frames when JTAG_REG_PARITY_EN is defined.
module jtag_reg_bank
  import jtag_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       NUM_REGS  = 10,
  parameter logic [31:0]       ID_CODE   = ID_CODE_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       JTCK,
  input  logic                       JRSTN,
  jtag_reg_bank_if.slave             jtag,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic [7:0]                 err_cnt
);

`ifdef JTAG_REG_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned BODY_W   = frame_w(ADDR_W, DATA_W);
  localparam int unsigned SHIFT_W  = BODY_W + PAR_W;
  localparam int unsigned DATA_LSB = data_lsb(ADDR_W);
  localparam int unsigned CW1      = cnt_w(SHIFT_W);
  localparam int unsigned CW2      = cnt_w(ER2_W);

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [ADDR_W-1:0]  rd_ptr;
  logic               last_ok;
  sel_e               sel;

  logic               cap_evt;
  logic [BODY_W-1:0]  er1_body;
  logic [SHIFT_W-1:0] er1_cap;
  logic [SHIFT_W-1:0] er1_sh;
  logic [CW1-1:0]     er1_cnt;
  logic [ER2_W-1:0]   er2_cap;
  logic [ER2_W-1:0]   unused_er2_sh;
  logic [CW2-1:0]     unused_er2_cnt;
  logic               unused_rti1;

  logic               f_wr;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data;
  logic               par_ok;
  logic               frame_ok;

  assign unused_rti1 = jtag.JRTI1;
  assign cap_evt     = (jtag.JCE1 | jtag.JCE2) & ~jtag.JSHIFT;

  assign er1_body = {regs[rd_ptr], rd_ptr, last_ok};
`ifdef JTAG_REG_PARITY_EN
  assign er1_cap = {^er1_body, er1_body};
  assign par_ok  = ~^er1_sh;
`else
  assign er1_cap = er1_body;
  assign par_ok  = 1'b1;
`endif
  assign er2_cap = {err_cnt, 24'h0, ID_CODE};

  assign f_wr     = er1_sh[0];
  assign f_addr   = er1_sh[ADDR_LSB +: ADDR_W];
  assign f_data   = er1_sh[DATA_LSB +: DATA_W];
  assign frame_ok = (er1_cnt == CW1'(SHIFT_W)) && ({1'b0, f_addr} < (ADDR_W+1)'(NUM_REGS)) && par_ok;

  jtag_shift_frame #(.W(SHIFT_W)) u_er1 (
    .clk      (JTCK),
    .rst_n    (JRSTN),
    .capture  (cap_evt & jtag.JCE1),
    .shift    (jtag.JCE1 & jtag.JSHIFT),
    .tdi      (jtag.JTDI),
    .cap_data (er1_cap),
    .shreg    (er1_sh),
    .bit_cnt  (er1_cnt),
    .tdo      (jtag.JTDO1)
  );

  // ER1 takes priority when both enables are high at capture
  jtag_shift_frame #(.W(ER2_W)) u_er2 (
    .clk      (JTCK),
    .rst_n    (JRSTN),
    .capture  (cap_evt & ~jtag.JCE1),
    .shift    (jtag.JCE2 & jtag.JSHIFT),
    .tdi      (jtag.JTDI),
    .cap_data (er2_cap),
    .shreg    (unused_er2_sh),
    .bit_cnt  (unused_er2_cnt),
    .tdo      (jtag.JTDO2)
  );

  always_ff @(posedge JTCK) begin
    if (!JRSTN) begin
      sel       <= SEL_NONE;
      rd_ptr    <= '0;
      last_ok   <= 1'b0;
      err_cnt   <= '0;
      wr_strobe <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL;
    end else begin
      wr_strobe <= '0;
      if (cap_evt)
        sel <= jtag.JCE1 ? SEL_ER1 : SEL_ER2;
      else if (jtag.JUPDATE)
        sel <= SEL_NONE;

      if (jtag.JUPDATE && sel == SEL_ER1) begin
        if (frame_ok) begin
          rd_ptr  <= f_addr;
          last_ok <= 1'b1;
          if (f_wr) begin
            regs[f_addr]      <= f_data;
            wr_strobe[f_addr] <= 1'b1;
          end
        end else begin
          last_ok <= 1'b0;
          if (err_cnt != '1)
            err_cnt <= err_cnt + 8'd1;
        end
      end

      if (jtag.JRTI2)
        err_cnt <= '0;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      reg_q[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: tb/tb_jtag_reg_bank.sv
// Directed testbench for jtag_reg_bank (DATA_W=32, ADDR_W=4, NUM_REGS=10);
// parity scenario runs only when JTAG_REG_PARITY_EN is defined.
module tb_jtag_reg_bank;

`ifdef JTAG_REG_PARITY_EN
  localparam int unsigned SW = 38;
`else
  localparam int unsigned SW = 37;
`endif

  logic         JTCK;
  logic         JRSTN;
  logic [319:0] reg_q;
  logic [9:0]   wr_strobe;
  logic [7:0]   err_cnt;

  logic [319:0] exp_q;
  logic [63:0]  dout;
  int           vectors;
  int           miscompares;

  jtag_reg_bank_if bus ();

  jtag_reg_bank #(
    .DATA_W    (32),
    .ADDR_W    (4),
    .NUM_REGS  (10),
    .ID_CODE   (32'h4A544731),
    .RESET_VAL (32'h0)
  ) dut (
    .JTCK      (JTCK),
    .JRSTN     (JRSTN),
    .jtag      (bus.slave),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .err_cnt   (err_cnt)
  );

  initial begin
    JTCK = 1'b0;
    forever #5 JTCK = ~JTCK;
  end

  task automatic tick();
    @(posedge JTCK);
    #1;
  endtask

  function automatic logic [63:0] mkframe(input logic wr, input logic [3:0] addr,
                                          input logic [31:0] data, input logic bad_par);
    logic [63:0] f;
    f = '0;
    f[36:0] = {data, addr, wr};
`ifdef JTAG_REG_PARITY_EN
    f[37] = (^f[36:0]) ^ bad_par;
`else
    if (bad_par) f = f;
`endif
    return f;
  endfunction

  // which: 1 = ER1, 2 = ER2, 3 = both enables high
  task automatic frame(input int unsigned which, input logic [63:0] din, input int unsigned n,
                       input logic rti2, output logic [63:0] d);
    d = '0;
    bus.JCE1 = (which != 2);
    bus.JCE2 = (which != 1);
    bus.JSHIFT = 1'b0;
    tick();
    bus.JSHIFT = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      bus.JTDI = din[i];
      tick();
      d[i] = (which == 2) ? bus.JTDO2 : bus.JTDO1;
    end
    bus.JSHIFT = 1'b0;
    bus.JCE1 = 1'b0;
    bus.JCE2 = 1'b0;
    bus.JTDI = 1'b0;
    bus.JUPDATE = 1'b1;
    bus.JRTI2 = rti2;
    tick();
    bus.JUPDATE = 1'b0;
    bus.JRTI2 = 1'b0;
  endtask

  task automatic test_reset();
    JRSTN = 1'b0;
    repeat (3) tick();
    vectors++; if (reg_q !== 320'h0) begin miscompares++; $display("FAIL reset_reg_q got %h want 0", reg_q); end
    vectors++; if (wr_strobe !== 10'h0) begin miscompares++; $display("FAIL reset_wr_strobe got %h want 0", wr_strobe); end
    vectors++; if (err_cnt !== 8'h0) begin miscompares++; $display("FAIL reset_err_cnt got %h want 0", err_cnt); end
    vectors++; if (bus.JTDO1 !== 1'b0) begin miscompares++; $display("FAIL reset_tdo1 got %b want 0", bus.JTDO1); end
    vectors++; if (bus.JTDO2 !== 1'b0) begin miscompares++; $display("FAIL reset_tdo2 got %b want 0", bus.JTDO2); end
    JRSTN = 1'b1;
    tick();
    exp_q = '0;
  endtask

  task automatic test_capture_zero();
    frame(1, mkframe(1'b0, 4'd0, 32'h0, 1'b0), SW, 1'b0, dout);
    vectors++; if (dout !== 64'h0) begin miscompares++; $display("FAIL cap_zero_tdo got %h want 0", dout); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL cap_zero_reg_q got %h want %h", reg_q, exp_q); end
    vectors++; if (err_cnt !== 8'h0) begin miscompares++; $display("FAIL cap_zero_err got %h want 0", err_cnt); end
  endtask

  task automatic test_write();
    frame(1, mkframe(1'b1, 4'd3, 32'hCAFE0123, 1'b0), SW, 1'b0, dout);
    exp_q[3*32 +: 32] = 32'hCAFE0123;
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL write3_reg_q got %h want %h", reg_q, exp_q); end
    vectors++; if (wr_strobe !== 10'b0000001000) begin miscompares++; $display("FAIL write3_strobe got %b want 0000001000", wr_strobe); end
    tick();
    vectors++; if (wr_strobe !== 10'h0) begin miscompares++; $display("FAIL write3_strobe_end got %b want 0", wr_strobe); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL write3_hold got %h want %h", reg_q, exp_q); end

    frame(1, mkframe(1'b1, 4'd9, 32'h0BADF00D, 1'b0), SW, 1'b0, dout);
    exp_q[9*32 +: 32] = 32'h0BADF00D;
    vectors++; if (wr_strobe !== 10'b1000000000) begin miscompares++; $display("FAIL write9_strobe got %b want 1000000000", wr_strobe); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL write9_reg_q got %h want %h", reg_q, exp_q); end

    frame(1, mkframe(1'b1, 4'd0, 32'h11112222, 1'b0), SW, 1'b0, dout);
    exp_q[31:0] = 32'h11112222;
    vectors++; if (wr_strobe !== 10'b0000000001) begin miscompares++; $display("FAIL write0_strobe got %b want 0000000001", wr_strobe); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL write0_reg_q got %h want %h", reg_q, exp_q); end
  endtask

  task automatic test_read();
    frame(1, mkframe(1'b0, 4'd3, 32'hFFFFFFFF, 1'b0), SW, 1'b0, dout);
    vectors++; if (dout !== mkframe(1'b1, 4'd0, 32'h11112222, 1'b0)) begin miscompares++; $display("FAIL read_cap0 got %h want %h", dout, mkframe(1'b1, 4'd0, 32'h11112222, 1'b0)); end
    vectors++; if (wr_strobe !== 10'h0) begin miscompares++; $display("FAIL read_no_strobe got %b want 0", wr_strobe); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL read_no_write got %h want %h", reg_q, exp_q); end
    frame(1, mkframe(1'b0, 4'd3, 32'h0, 1'b0), SW, 1'b0, dout);
    vectors++; if (dout !== mkframe(1'b1, 4'd3, 32'hCAFE0123, 1'b0)) begin miscompares++; $display("FAIL read_reg3 got %h want %h", dout, mkframe(1'b1, 4'd3, 32'hCAFE0123, 1'b0)); end
  endtask

  task automatic test_errors();
    frame(1, mkframe(1'b1, 4'd1, 32'hAAAA5555, 1'b0), SW - 1, 1'b0, dout);
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL short_err got %0d want 1", err_cnt); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL short_reg_q got %h want %h", reg_q, exp_q); end
    frame(1, mkframe(1'b1, 4'd1, 32'hAAAA5555, 1'b0), SW + 1, 1'b0, dout);
    vectors++; if (err_cnt !== 8'd2) begin miscompares++; $display("FAIL long_err got %0d want 2", err_cnt); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL long_reg_q got %h want %h", reg_q, exp_q); end
    frame(1, mkframe(1'b1, 4'd12, 32'h5555AAAA, 1'b0), SW, 1'b0, dout);
    vectors++; if (err_cnt !== 8'd3) begin miscompares++; $display("FAIL addr12_err got %0d want 3", err_cnt); end
    vectors++; if (wr_strobe !== 10'h0) begin miscompares++; $display("FAIL addr12_strobe got %b want 0", wr_strobe); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL addr12_reg_q got %h want %h", reg_q, exp_q); end
    // last_ok=0 and rd_ptr still 3 after the rejected frames
    frame(1, mkframe(1'b0, 4'd3, 32'h0, 1'b0), SW, 1'b0, dout);
    vectors++; if (dout !== mkframe(1'b0, 4'd3, 32'hCAFE0123, 1'b0)) begin miscompares++; $display("FAIL err_last_ok got %h want %h", dout, mkframe(1'b0, 4'd3, 32'hCAFE0123, 1'b0)); end
    vectors++; if (err_cnt !== 8'd3) begin miscompares++; $display("FAIL probe_err got %0d want 3", err_cnt); end
    bus.JRTI2 = 1'b1;
    tick();
    bus.JRTI2 = 1'b0;
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rti2_clear got %0d want 0", err_cnt); end
    frame(1, mkframe(1'b1, 4'd1, 32'h0, 1'b0), SW - 1, 1'b1, dout);
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL clear_wins got %0d want 0", err_cnt); end
  endtask

  task automatic test_er2();
    frame(1, mkframe(1'b1, 4'd1, 32'h0, 1'b0), SW - 1, 1'b0, dout);
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL er2_pre_err got %0d want 1", err_cnt); end
    frame(2, 64'h0, 64, 1'b0, dout);
    vectors++; if (dout[31:0] !== 32'h4A544731) begin miscompares++; $display("FAIL er2_id got %h want 4a544731", dout[31:0]); end
    vectors++; if (dout[55:32] !== 24'h0) begin miscompares++; $display("FAIL er2_pad got %h want 0", dout[55:32]); end
    vectors++; if (dout[63:56] !== 8'd1) begin miscompares++; $display("FAIL er2_err got %h want 01", dout[63:56]); end
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL er2_update_err got %0d want 1", err_cnt); end
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL er2_update_reg_q got %h want %h", reg_q, exp_q); end
    bus.JUPDATE = 1'b1;
    tick();
    bus.JUPDATE = 1'b0;
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL none_update_err got %0d want 1", err_cnt); end
  endtask

  task automatic test_both_ce();
    frame(3, mkframe(1'b0, 4'd9, 32'h0, 1'b0), SW, 1'b0, dout);
    vectors++; if (dout !== mkframe(1'b0, 4'd3, 32'hCAFE0123, 1'b0)) begin miscompares++; $display("FAIL both_ce_tdo1 got %h want %h", dout, mkframe(1'b0, 4'd3, 32'hCAFE0123, 1'b0)); end
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL both_ce_err got %0d want 1", err_cnt); end
    frame(1, mkframe(1'b0, 4'd9, 32'h0, 1'b0), SW, 1'b0, dout);
    vectors++; if (dout !== mkframe(1'b1, 4'd9, 32'h0BADF00D, 1'b0)) begin miscompares++; $display("FAIL both_ce_read9 got %h want %h", dout, mkframe(1'b1, 4'd9, 32'h0BADF00D, 1'b0)); end
  endtask

  task automatic test_mid_reset();
    logic [63:0] din;
    din = mkframe(1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
    bus.JCE1 = 1'b1;
    bus.JSHIFT = 1'b0;
    tick();
    bus.JSHIFT = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      bus.JTDI = din[i];
      tick();
    end
    JRSTN = 1'b0;
    tick();
    JRSTN = 1'b1;
    for (int unsigned i = 20; i < SW; i++) begin
      bus.JTDI = din[i];
      tick();
    end
    bus.JSHIFT = 1'b0;
    bus.JCE1 = 1'b0;
    bus.JUPDATE = 1'b1;
    tick();
    bus.JUPDATE = 1'b0;
    exp_q = '0;
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL mid_reset_reg_q got %h want 0", reg_q); end
    vectors++; if (wr_strobe !== 10'h0) begin miscompares++; $display("FAIL mid_reset_strobe got %b want 0", wr_strobe); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_reset_err got %0d want 0", err_cnt); end
  endtask

`ifdef JTAG_REG_PARITY_EN
  task automatic test_parity();
    frame(1, mkframe(1'b1, 4'd4, 32'h13572468, 1'b1), SW, 1'b0, dout);
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL parity_bad_reg_q got %h want %h", reg_q, exp_q); end
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL parity_bad_err got %0d want 1", err_cnt); end
    frame(1, mkframe(1'b1, 4'd4, 32'h13572468, 1'b0), SW, 1'b0, dout);
    exp_q[4*32 +: 32] = 32'h13572468;
    vectors++; if (reg_q !== exp_q) begin miscompares++; $display("FAIL parity_good_reg_q got %h want %h", reg_q, exp_q); end
    vectors++; if (wr_strobe !== 10'b0000010000) begin miscompares++; $display("FAIL parity_good_strobe got %b want 0000010000", wr_strobe); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    JRSTN = 1'b0;
    bus.JTDI = 1'b0;
    bus.JSHIFT = 1'b0;
    bus.JUPDATE = 1'b0;
    bus.JCE1 = 1'b0;
    bus.JCE2 = 1'b0;
    bus.JRTI1 = 1'b0;
    bus.JRTI2 = 1'b0;
    exp_q = '0;
    dout = '0;
    test_reset();
    test_capture_zero();
    test_write();
    test_read();
    test_errors();
    test_er2();
    test_both_ce();
    test_mid_reset();
`ifdef JTAG_REG_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
